// File: rtl/sdram_rw_arbiter_pkg.sv
// Shared definitions for the SDRAM read/write/refresh arbiter: state encodings
// and the default burst and refresh parameters.
package sdram_rw_arbiter_pkg;

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_REF,
        S_WR,
        S_RD
    } state_t;

    localparam int AW_DEF         = 24;
    localparam int UW_DEF         = 10;
    localparam int BURST_DEF      = 8;
    localparam int RD_DEPTH_DEF   = 512;
    localparam int REF_PERIOD_DEF = 780;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer: raises a pending refresh every REF_PERIOD cycles and
// flags a miss when a new interval expires before the previous refresh was served.
module sdram_ref_timer
    import sdram_rw_arbiter_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_enable,
    input  logic i_ref_ack,
    output logic o_ref_pend,
    output logic o_ref_miss
);

    localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(REF_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          r_ref_pend;
    logic          r_ref_miss;
    logic          w_tick;

    assign w_tick = i_enable && (r_cnt == LAST);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_cnt      <= '0;
            r_ref_pend <= 1'b0;
            r_ref_miss <= 1'b0;
        end else begin
            r_ref_miss <= 1'b0;
            if (i_ref_ack) begin
                r_ref_pend <= 1'b0;
            end
            // A tick overrides a same-edge acknowledge so that interval is not lost.
            if (i_enable) begin
                if (w_tick) begin
                    r_cnt      <= '0;
                    r_ref_pend <= 1'b1;
                    r_ref_miss <= r_ref_pend;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_ref_pend = r_ref_pend;
    assign o_ref_miss = r_ref_miss;

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Schedules one SDRAM operation at a time (refresh, write burst, read burst) and
// tracks wrapping burst addresses for the write and read regions.
module sdram_rw_arbiter
    import sdram_rw_arbiter_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int UW         = UW_DEF,
    parameter int BURST      = BURST_DEF,
    parameter int RD_DEPTH   = RD_DEPTH_DEF,
    parameter int REF_PERIOD = REF_PERIOD_DEF
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Init_done,
    input  logic [UW-1:0] Wr_use,
    input  logic [UW-1:0] Rd_use,
    input  logic          Rd_en,
    input  logic [AW-1:0] Wr_addr,
    input  logic [AW-1:0] Wr_max_addr,
    input  logic [AW-1:0] Rd_addr,
    input  logic [AW-1:0] Rd_max_addr,
    input  logic          Wr_load,
    input  logic          Rd_load,
    output logic          Ref_req,
    output logic          Wr_req,
    output logic          Rd_req,
    output logic [AW-1:0] Op_addr,
    input  logic          Op_done,
    output logic          Ref_miss
);

    localparam logic [UW:0]   BURST_U    = (UW+1)'(BURST);
    localparam logic [UW+1:0] BURST_X    = (UW+2)'(BURST);
    localparam logic [UW+1:0] RD_DEPTH_X = (UW+2)'(RD_DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ref_req;
    logic          r_wr_req;
    logic          r_rd_req;
    logic [AW-1:0] r_op_addr;
    logic [AW-1:0] w_op_addr_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic          r_last_wr;
    logic [UW+1:0] w_rd_space;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_wr_done;
    logic          w_rd_done;
    logic          w_ref_ack;
    logic          w_ref_pend;

    // Advance by one burst; restart at the base if the next burst would run past the last word.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr,
                                               input logic [AW-1:0] base,
                                               input logic [AW-1:0] last);
        logic [AW:0] nxt;
        nxt = {1'b0, ptr} + (AW+1)'(BURST);
        if (nxt + (AW+1)'(BURST - 1) > {1'b0, last}) begin
            return base;
        end
        return nxt[AW-1:0];
    endfunction

    assign w_rd_space = RD_DEPTH_X - {2'b00, Rd_use};
    assign w_wr_ok    = ({1'b0, Wr_use} >= BURST_U);
    assign w_rd_ok    = Rd_en && !w_rd_space[UW+1] && (w_rd_space >= BURST_X);
    assign w_wr_done  = (r_state == S_WR) && Op_done;
    assign w_rd_done  = (r_state == S_RD) && Op_done;
    assign w_ref_ack  = (r_state == S_REF) && Op_done;

    sdram_ref_timer #(
        .REF_PERIOD(REF_PERIOD)
    ) u_ref_timer (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .i_enable  (r_state != S_WAIT_INIT),
        .i_ref_ack (w_ref_ack),
        .o_ref_pend(w_ref_pend),
        .o_ref_miss(Ref_miss)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_op_addr_nxt = r_op_addr;
        unique case (r_state)
            S_WAIT_INIT: begin
                if (Init_done) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_ref_pend) begin
                    w_state_nxt = S_REF;
                end else if (w_wr_ok && (!w_rd_ok || !r_last_wr)) begin
                    w_state_nxt   = S_WR;
                    w_op_addr_nxt = r_wr_ptr;
                end else if (w_rd_ok) begin
                    w_state_nxt   = S_RD;
                    w_op_addr_nxt = r_rd_ptr;
                end
            end
            S_REF, S_WR, S_RD: begin
                if (Op_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_WAIT_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state   <= S_WAIT_INIT;
            r_ref_req <= 1'b0;
            r_wr_req  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_op_addr <= '0;
            r_last_wr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ref_req <= (w_state_nxt == S_REF);
            r_wr_req  <= (w_state_nxt == S_WR);
            r_rd_req  <= (w_state_nxt == S_RD);
            r_op_addr <= w_op_addr_nxt;
            if (w_wr_done) begin
                r_last_wr <= 1'b1;
            end else if (w_rd_done) begin
                r_last_wr <= 1'b0;
            end
        end
    end

    // An explicit load takes precedence over a completion-driven advance.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_wr_ptr <= Wr_addr;
            r_rd_ptr <= Rd_addr;
        end else begin
            if (Wr_load) begin
                r_wr_ptr <= Wr_addr;
            end else if (w_wr_done) begin
                r_wr_ptr <= next_ptr(r_wr_ptr, Wr_addr, Wr_max_addr);
            end
            if (Rd_load) begin
                r_rd_ptr <= Rd_addr;
            end else if (w_rd_done) begin
                r_rd_ptr <= next_ptr(r_rd_ptr, Rd_addr, Rd_max_addr);
            end
        end
    end

    assign Ref_req = r_ref_req;
    assign Wr_req  = r_wr_req;
    assign Rd_req  = r_rd_req;
    assign Op_addr = r_op_addr;

    a_one_req: assert property (@(posedge Clk) $onehot0({Ref_req, Wr_req, Rd_req}));

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Self-checking bench for sdram_rw_arbiter: vector table of grant sequences with a
// scoreboard of expected grants, plus hand-written refresh and reset sequences.
module tb_sdram_rw_arbiter;

    localparam int AW         = 24;
    localparam int UW         = 10;
    localparam int BURST      = 8;
    localparam int RD_DEPTH   = 512;
    localparam int REF_PERIOD = 100;
    localparam logic [AW-1:0] MAX = {AW{1'b1}};
    localparam int K_NONE = 0;
    localparam int K_REF  = 1;
    localparam int K_WR   = 2;
    localparam int K_RD   = 3;
    localparam int NV     = 15;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          Init_done;
    logic [UW-1:0] Wr_use;
    logic [UW-1:0] Rd_use;
    logic          Rd_en;
    logic [AW-1:0] Wr_addr;
    logic [AW-1:0] Wr_max_addr;
    logic [AW-1:0] Rd_addr;
    logic [AW-1:0] Rd_max_addr;
    logic          Wr_load;
    logic          Rd_load;
    logic          Ref_req;
    logic          Wr_req;
    logic          Rd_req;
    logic [AW-1:0] Op_addr;
    logic          Op_done;
    logic          Ref_miss;

    sdram_rw_arbiter #(
        .AW(AW), .UW(UW), .BURST(BURST), .RD_DEPTH(RD_DEPTH), .REF_PERIOD(REF_PERIOD)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Init_done(Init_done),
        .Wr_use(Wr_use), .Rd_use(Rd_use), .Rd_en(Rd_en),
        .Wr_addr(Wr_addr), .Wr_max_addr(Wr_max_addr),
        .Rd_addr(Rd_addr), .Rd_max_addr(Rd_max_addr),
        .Wr_load(Wr_load), .Rd_load(Rd_load),
        .Ref_req(Ref_req), .Wr_req(Wr_req), .Rd_req(Rd_req),
        .Op_addr(Op_addr), .Op_done(Op_done), .Ref_miss(Ref_miss)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          rst;
        logic [UW-1:0] wr_use;
        logic [UW-1:0] rd_use;
        logic          rd_en;
        logic [AW-1:0] wr_max;
        logic          ld;
        logic [AW-1:0] ld_addr;
        int            kind;
        logic [AW-1:0] addr;
    } vec_t;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
    } grant_t;

    vec_t   vecs[NV];
    grant_t sb_q[$];
    int     checks   = 0;
    int     failures = 0;

    function automatic int kind();
        case ({Ref_req, Wr_req, Rd_req})
            3'b000:  return K_NONE;
            3'b100:  return K_REF;
            3'b010:  return K_WR;
            3'b001:  return K_RD;
            default: return 7;
        endcase
    endfunction

    function automatic vec_t mk(input logic rst, input int wu, input int ru, input logic re,
                                input logic [AW-1:0] wmax, input logic ld, input int lda,
                                input int k, input int a);
        vec_t v;
        v.rst = rst; v.wr_use = UW'(wu); v.rd_use = UW'(ru); v.rd_en = re;
        v.wr_max = wmax; v.ld = ld; v.ld_addr = AW'(lda); v.kind = k; v.addr = AW'(a);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic expect_grant(input int k, input int a);
        grant_t g;
        g.kind = k;
        g.addr = AW'(a);
        sb_q.push_back(g);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0; Init_done = 1'b0; Op_done = 1'b0;
        Wr_load = 1'b0; Rd_load = 1'b0;
        Wr_addr = '0; Rd_addr = '0; Wr_max_addr = MAX; Rd_max_addr = MAX;
        repeat (2) @(negedge Clk);
        chk("reset_req", kind(), K_NONE);
        chk("reset_addr", int'(Op_addr), 0);
        chk("reset_miss", int'(Ref_miss), 0);
        Rst_n = 1'b1;
    endtask

    // Wait for a grant, compare it against the scoreboard head, then acknowledge it.
    task automatic serve(input int hold, input logic ld, input logic [AW-1:0] ld_addr);
        int     n;
        grant_t e;
        n = 0;
        while (kind() == K_NONE && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (kind() == K_NONE) begin
            chk("grant_timeout", n, -1);
            return;
        end
        if (sb_q.size() == 0) begin
            chk("unexpected_grant", kind(), K_NONE);
            return;
        end
        e = sb_q.pop_front();
        chk("grant_kind", kind(), e.kind);
        if (e.kind != K_REF) chk("grant_addr", int'(Op_addr), int'(e.addr));
        repeat (hold) @(negedge Clk);
        chk("req_held", kind(), e.kind);
        Op_done = 1'b1;
        if (ld) begin
            Wr_addr = ld_addr;
            Wr_load = 1'b1;
        end
        @(negedge Clk);
        Op_done = 1'b0;
        Wr_load = 1'b0;
        chk("req_drop", kind(), K_NONE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int misses;
        int seen;

        // Write-only, then alternating, wrap, load-over-done, and FIFO threshold edges.
        vecs[0]  = mk(1'b1,  8,   0, 1'b0, MAX,   1'b0, 0,   K_WR, 0);
        vecs[1]  = mk(1'b0,  8,   0, 1'b0, MAX,   1'b0, 0,   K_WR, 8);
        vecs[2]  = mk(1'b1, 16,   0, 1'b1, MAX,   1'b0, 0,   K_WR, 0);
        vecs[3]  = mk(1'b0, 16,   0, 1'b1, MAX,   1'b0, 0,   K_RD, 0);
        vecs[4]  = mk(1'b0, 16,   0, 1'b1, MAX,   1'b0, 0,   K_WR, 8);
        vecs[5]  = mk(1'b0, 16,   0, 1'b1, MAX,   1'b0, 0,   K_RD, 8);
        vecs[6]  = mk(1'b1,  8,   0, 1'b0, 24'd23, 1'b0, 0,  K_WR, 0);
        vecs[7]  = mk(1'b0,  8,   0, 1'b0, 24'd23, 1'b0, 0,  K_WR, 8);
        vecs[8]  = mk(1'b0,  8,   0, 1'b0, 24'd23, 1'b0, 0,  K_WR, 16);
        vecs[9]  = mk(1'b0,  8,   0, 1'b0, 24'd23, 1'b0, 0,  K_WR, 0);
        vecs[10] = mk(1'b1,  8,   0, 1'b0, MAX,   1'b1, 100, K_WR, 0);
        vecs[11] = mk(1'b0,  8,   0, 1'b0, MAX,   1'b0, 0,   K_WR, 100);
        vecs[12] = mk(1'b1,  7, 504, 1'b1, MAX,   1'b0, 0,   K_RD, 0);
        vecs[13] = mk(1'b0,  8, 505, 1'b1, MAX,   1'b0, 0,   K_WR, 0);
        vecs[14] = mk(1'b0,  8, 504, 1'b1, MAX,   1'b0, 0,   K_RD, 8);

        // Grant latency after init.
        Wr_use = '0; Rd_use = '0; Rd_en = 1'b0;
        do_reset();
        Wr_use = 10'd8;
        Init_done = 1'b1;
        @(negedge Clk);
        chk("lat_idle", kind(), K_NONE);
        @(negedge Clk);
        chk("lat_wr", kind(), K_WR);
        chk("lat_addr", int'(Op_addr), 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) begin
                do_reset();
                Init_done = 1'b1;
            end
            Wr_use      = vecs[i].wr_use;
            Rd_use      = vecs[i].rd_use;
            Rd_en       = vecs[i].rd_en;
            Wr_max_addr = vecs[i].wr_max;
            expect_grant(vecs[i].kind, int'(vecs[i].addr));
            serve(1, vecs[i].ld, vecs[i].ld_addr);
        end

        // Refresh: grant, one miss on the second tick, re-grant on the next tick.
        do_reset();
        Wr_use = '0; Rd_use = '0; Rd_en = 1'b0;
        Init_done = 1'b1;
        n = 0;
        while (!Ref_req && n < 250) begin
            @(negedge Clk);
            n++;
        end
        chk("ref_grant", kind(), K_REF);
        misses = 0;
        repeat (150) begin
            @(negedge Clk);
            if (Ref_miss) misses++;
        end
        chk("ref_miss_count", misses, 1);
        chk("ref_held", kind(), K_REF);
        Op_done = 1'b1;
        @(negedge Clk);
        Op_done = 1'b0;
        chk("ref_drop", kind(), K_NONE);
        n = 0;
        while (!Ref_req && n < 150) begin
            @(negedge Clk);
            n++;
        end
        chk("ref_regrant", kind(), K_REF);

        // Reset during a read burst.
        do_reset();
        Wr_use = '0; Rd_use = '0; Rd_en = 1'b1;
        Init_done = 1'b1;
        expect_grant(K_RD, 0);
        serve(1, 1'b0, '0);
        n = 0;
        while (!Rd_req && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("rd_inflight", kind(), K_RD);
        chk("rd_inflight_addr", int'(Op_addr), 8);
        Rst_n = 1'b0;
        Init_done = 1'b0;
        @(negedge Clk);
        chk("abort_req", kind(), K_NONE);
        chk("abort_addr", int'(Op_addr), 0);
        Rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge Clk);
            if (kind() != K_NONE) seen = 1;
        end
        chk("no_req_before_init", seen, 0);
        Init_done = 1'b1;
        expect_grant(K_RD, 0);
        serve(1, 1'b0, '0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
